// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO.
// Frames are sent back to back while the FIFO holds data; overflow is sticky until reset.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 115,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iWR,
  input  logic [7:0]                    iWDATA,
  output logic                          oTX,
  output logic                          oFULL,
  output logic                          oEMPTY,
  output logic                          oBUSY,
  output logic [$clog2(FIFO_DEPTH):0]   oCOUNT,
  output logic                          oOVF
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT              state, stateNext;
  logic [BAUD_W-1:0]  baudCnt, baudNext;
  logic [2:0]         bitIdx, bitNext;
  logic [7:0]         shiftReg, shiftNext;
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [CNT_W-1:0]   count, countNext;
  logic [7:0]         mem [FIFO_DEPTH];
  logic               pop, wrAcc, baudEnd, txNext;
  logic               txReg, fullReg, emptyReg, busyReg, ovfReg;

  assign baudEnd = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));

  // Next-state, pop decision and next line level
  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    pop       = 1'b0;
    txNext    = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          shiftNext = mem[rdPtr];
          baudNext  = '0;
          stateNext = START;
        end
      end
      START: begin
        if (baudEnd) begin
          baudNext  = '0;
          bitNext   = '0;
          stateNext = DATA;
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baudEnd) begin
          baudNext  = '0;
          shiftNext = {1'b0, shiftReg[7:1]};
          if (bitIdx == 3'd7) stateNext = STOP;
          else                bitNext   = bitIdx + 3'd1;
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baudEnd) begin
          baudNext = '0;
          // Chain straight into the next start bit when data is waiting
          if (count != '0) begin
            pop       = 1'b1;
            shiftNext = mem[rdPtr];
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          baudNext = baudCnt + BAUD_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
      default: txNext = 1'b1;
    endcase
    wrAcc     = iWR && (count < CNT_W'(FIFO_DEPTH));
    countNext = count + CNT_W'(wrAcc) - CNT_W'(pop);
  end

  // State, FIFO bookkeeping and registered outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      ovfReg   <= 1'b0;
      txReg    <= 1'b1;
      fullReg  <= 1'b0;
      emptyReg <= 1'b1;
      busyReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      count    <= countNext;
      if (wrAcc)        wrPtr  <= wrPtr + PTR_W'(1);
      if (pop)          rdPtr  <= rdPtr + PTR_W'(1);
      if (iWR && !wrAcc) ovfReg <= 1'b1;
      txReg    <= txNext;
      fullReg  <= (countNext == CNT_W'(FIFO_DEPTH));
      emptyReg <= (countNext == '0);
      busyReg  <= (stateNext != IDLE);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST && wrAcc) mem[wrPtr] <= iWDATA;
  end

  assign oTX    = txReg;
  assign oFULL  = fullReg;
  assign oEMPTY = emptyReg;
  assign oBUSY  = busyReg;
  assign oCOUNT = count;
  assign oOVF   = ovfReg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, compared every
// cycle against a queue-and-frame-timeline model of the transmitter.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       iRST = 1'b1;
  logic       iWR = 1'b0;
  logic [7:0] iWDATA = 8'h00;
  logic       oTX, oFULL, oEMPTY, oBUSY, oOVF;
  logic [3:0] oCOUNT;

  int compared = 0;
  int mismatched = 0;

  // Model: queued bytes, current frame byte and position within the frame
  logic [7:0] q[$];
  bit         active = 1'b0;
  int         elapsed = 0;
  logic [7:0] curByte = 8'h00;
  bit         ovfM = 1'b0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .iCLK(clk), .iRST(iRST), .iWR(iWR), .iWDATA(iWDATA),
    .oTX(oTX), .oFULL(oFULL), .oEMPTY(oEMPTY), .oBUSY(oBUSY),
    .oCOUNT(oCOUNT), .oOVF(oOVF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic expTx();
    int k;
    if (!active) return 1'b1;
    k = elapsed / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return curByte[k-1];
  endfunction

  task automatic step(input logic wr, input logic [7:0] d, input logic rst);
    int pre;
    bit doPop;
    iWR = wr; iWDATA = d; iRST = rst;
    @(posedge clk);
    if (rst) begin
      q.delete(); active = 1'b0; elapsed = 0; ovfM = 1'b0;
    end else begin
      pre = q.size();
      doPop = 1'b0;
      if (!active) doPop = (pre > 0);
      else if (elapsed == FRAME - 1) begin
        doPop = (pre > 0);
        if (!doPop) active = 1'b0;
      end else elapsed++;
      if (wr) begin
        if (pre < DEPTH) q.push_back(d);
        else ovfM = 1'b1;
      end
      if (doPop) begin
        curByte = q.pop_front(); active = 1'b1; elapsed = 0;
      end
    end
    #1;
    check("tx",    8'(oTX),    8'(expTx()));
    check("count", 8'(oCOUNT), 8'(q.size()));
    check("full",  8'(oFULL),  8'(q.size() == DEPTH));
    check("empty", 8'(oEMPTY), 8'(q.size() == 0));
    check("busy",  8'(oBUSY),  8'(active));
    check("ovf",   8'(oOVF),   8'(ovfM));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Advance until the model sits at a given frame position; expiry counts as a failure
  task automatic waitPos(input string tag, input int pos);
    int guard;
    guard = 0;
    while (!(active && elapsed == pos) && guard < 1000) begin
      step(1'b0, 8'h00, 1'b0);
      guard++;
    end
    check(tag, 8'(guard < 1000), 8'd1);
  endtask

  initial begin
    int nxt;
    logic wr;
    // Reset with a write strobe that must be ignored
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'hFF, 1'b1);

    // Single byte from idle
    step(1'b1, 8'hA5, 1'b0);
    idle(FRAME + 5);

    // Three consecutive writes, contiguous frames
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    idle(3 * FRAME + 5);

    // Fill while busy: 9 writes, last one dropped
    step(1'b1, 8'h11, 1'b0);
    idle(2);
    for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0);
    idle(9 * FRAME + 5);

    // Full FIFO with a write on the stop-end pop edge
    step(1'b1, 8'h21, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    waitPos("wait_stop_end", FRAME - 1);
    step(1'b1, 8'hEE, 1'b0);
    check("ovf_on_pop_edge", 8'(oOVF), 8'd1);
    check("count_after_pop", 8'(oCOUNT), 8'd7);

    // Reset in the middle of data bit 3, then normal transmission
    waitPos("wait_bit3", 4 * CPB + 1);
    step(1'b1, 8'h99, 1'b1);
    step(1'b1, 8'h3C, 1'b0);
    idle(FRAME + 5);

    // Stream 0x00..0x13 through the wrapping pointers
    nxt = 0;
    for (int g = 0; g < 3000 && nxt < 20; g++) begin
      wr = (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      step(wr, 8'(nxt), 1'b0);
      if (wr) nxt++;
    end
    check("stream_done", 8'(nxt), 8'd20);
    idle(9 * FRAME + 5);

    // Random traffic with occasional reset
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom_range(0, 499) == 0));
    idle(9 * FRAME + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
